// File: rtl/pipe_scheduler_if.sv
// Bundle between the game controller and the pipe scheduler.
// Signalling: there is no valid/ready flow control on this bus. frame_tick
// and clear are single-cycle strobes sampled on the rising clock edge.
// game_en and bird_x are levels. Every output is registered, and is valid
// the cycle after the edge that produced it. score_inc is a one-cycle strobe.
// dbg_state exposes the scheduler FSM: 0 IDLE, 1 RUN, 2 FREEZE.
interface pipe_scheduler_if #(
    parameter int N_PIPES = 3
);
    logic                    game_en;
    logic                    frame_tick;
    logic                    clear;
    logic [9:0]              bird_x;
    logic [10*N_PIPES-1:0]   pipe_x;
    logic [10*N_PIPES-1:0]   pipe_gap_y;
    logic [N_PIPES-1:0]      pipe_active;
    logic                    score_inc;
    logic [13:0]             score;
    logic [1:0]              dbg_state;

    modport master (
        output game_en, frame_tick, clear, bird_x,
        input  pipe_x, pipe_gap_y, pipe_active, score_inc, score, dbg_state
    );

    modport slave (
        input  game_en, frame_tick, clear, bird_x,
        output pipe_x, pipe_gap_y, pipe_active, score_inc, score, dbg_state
    );
endinterface

// File: rtl/pipe_scheduler.sv
// Pipe scheduler: spawns, scrolls, retires and scores the obstacle pipes once
// per video frame while the game runs. It freezes when play stops, and returns
// to IDLE on clear.
// Optional feature macro PIPE_SPEEDUP_EN: the scroll speed rises with the score.
// The scroll speed is SPEED + min(score/8, 2).
module pipe_scheduler #(
    parameter int N_PIPES      = 3,
    parameter int SCREEN_W     = 640,
    parameter int PIPE_W       = 52,
    parameter int SPAWN_FRAMES = 110,
    parameter int SPEED        = 2,
    parameter int GAP_MIN      = 60,
    parameter int SCORE_MAX    = 9999
) (
    input  logic             clk,
    input  logic             reset_n,
    pipe_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam int NS_W  = $clog2(N_PIPES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_FRAMES - 1);
    localparam logic [10:0]      PIPE_W11 = 11'(PIPE_W);

    state_t             state_q, state_d;
    logic [9:0]         x_q   [N_PIPES];
    logic [9:0]         x_d   [N_PIPES];
    logic [9:0]         gap_q [N_PIPES];
    logic [9:0]         gap_d [N_PIPES];
    logic [N_PIPES-1:0] act_q, act_d;
    logic [N_PIPES-1:0] scored_q, scored_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [13:0]        score_q, score_d;
    logic               inc_q, inc_d;
    logic [9:0]         speed;

`ifdef PIPE_SPEEDUP_EN
    logic [9:0]         speed_q, speed_d;
    assign speed = speed_q;
`else
    assign speed = 10'(SPEED);
`endif

    logic               run_tick;
    logic               spawn_now;
    logic               slot_found;
    int                 spawn_idx;
    logic [NS_W-1:0]    n_scored;
    logic [14:0]        score_sum;
    logic [10:0]        right_edge;

    // FSM next state. clear has the highest priority, and FREEZE ignores game_en.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.game_en)  state_d = ST_RUN;
            ST_RUN:    if (!bus.game_en) state_d = ST_FREEZE;
            ST_FREEZE: state_d = ST_FREEZE;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.clear) state_d = ST_IDLE;
    end

    // Per-frame datapath: move/retire, score, spawn, and advance the LFSR.
    always_comb begin
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        act_d      = act_q;
        scored_d   = scored_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        score_d    = score_q;
        inc_d      = 1'b0;
        for (int i = 0; i < N_PIPES; i++) begin
            x_d[i]   = x_q[i];
            gap_d[i] = gap_q[i];
        end
`ifdef PIPE_SPEEDUP_EN
        speed_d    = speed_q;
`endif
        run_tick   = (state_q == ST_RUN) && bus.game_en && bus.frame_tick && !bus.clear;
        spawn_now  = 1'b0;
        slot_found = 1'b0;
        spawn_idx  = 0;
        n_scored   = '0;
        score_sum  = '0;
        right_edge = '0;

        if (bus.clear || state_q == ST_IDLE) begin
            act_d    = '0;
            scored_d = '0;
            cnt_d    = '0;
            first_d  = 1'b1;
            score_d  = '0;
            for (int i = 0; i < N_PIPES; i++) begin
                x_d[i]   = '0;
                gap_d[i] = '0;
            end
`ifdef PIPE_SPEEDUP_EN
            speed_d  = 10'(SPEED);
`endif
        end else if (run_tick) begin
            // The first tick after entering RUN spawns at once. Later spawns occur every SPAWN_FRAMES ticks.
            spawn_now = first_q || (cnt_q == CNT_LAST);
            cnt_d     = spawn_now ? '0 : cnt_q + CNT_W'(1);
            first_d   = 1'b0;

            // Spawn target is picked from occupancy before this tick's retirements.
            for (int i = N_PIPES - 1; i >= 0; i--) begin
                if (!act_q[i]) begin
                    slot_found = 1'b1;
                    spawn_idx  = i;
                end
            end

            for (int i = 0; i < N_PIPES; i++) begin
                if (act_q[i]) begin
                    if (x_q[i] < speed) begin
                        act_d[i] = 1'b0;
                        x_d[i]   = '0;
                        gap_d[i] = '0;
                    end else begin
                        x_d[i]     = x_q[i] - speed;
                        right_edge = {1'b0, x_d[i]} + PIPE_W11;
                        if (!scored_q[i] && (right_edge < {1'b0, bus.bird_x})) begin
                            scored_d[i] = 1'b1;
                            n_scored    = n_scored + NS_W'(1);
                        end
                    end
                end
            end

            if (spawn_now && slot_found) begin
                act_d[spawn_idx]    = 1'b1;
                scored_d[spawn_idx] = 1'b0;
                x_d[spawn_idx]      = 10'(SCREEN_W);
                gap_d[spawn_idx]    = 10'(GAP_MIN) + {2'b00, lfsr_q};
            end

            score_sum = {1'b0, score_q} + 15'(n_scored);
            score_d   = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
            inc_d     = (n_scored != '0);
`ifdef PIPE_SPEEDUP_EN
            speed_d   = 10'(SPEED) + ((score_d[13:3] >= 11'd2) ? 10'd2 : 10'(score_d[13:3]));
`endif
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            act_q    <= '0;
            scored_q <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            lfsr_q   <= 8'hA5;
            score_q  <= '0;
            inc_q    <= 1'b0;
            for (int i = 0; i < N_PIPES; i++) begin
                x_q[i]   <= '0;
                gap_q[i] <= '0;
            end
`ifdef PIPE_SPEEDUP_EN
            speed_q  <= 10'(SPEED);
`endif
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            scored_q <= scored_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            lfsr_q   <= lfsr_d;
            score_q  <= score_d;
            inc_q    <= inc_d;
            for (int i = 0; i < N_PIPES; i++) begin
                x_q[i]   <= x_d[i];
                gap_q[i] <= gap_d[i];
            end
`ifdef PIPE_SPEEDUP_EN
            speed_q  <= speed_d;
`endif
        end
    end

    // Pack per-slot registers onto the flat output buses.
    always_comb begin
        bus.pipe_x     = '0;
        bus.pipe_gap_y = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            bus.pipe_x[10*i +: 10]     = x_q[i];
            bus.pipe_gap_y[10*i +: 10] = gap_q[i];
        end
    end

    assign bus.pipe_active = act_q;
    assign bus.score_inc   = inc_q;
    assign bus.score       = score_q;
    assign bus.dbg_state   = state_q;

endmodule
